wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2_pkg.sv | 21 ++
 rtl/wb_arbiter2_if.sv | 19 +
 rtl/wb_timeout_cnt.sv | 32 +++
 rtl/wb_arbiter2.sv | 107 ++++++++++
 tb/tb_wb_arbiter2.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter2_pkg.sv
// Shared Wishbone widths, arbiter state encoding and watchdog width helper.
// Imported by the arbiter, its interface and the timeout counter.
package wb_arbiter2_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_t;

  // Enough bits to hold TIMEOUT itself; never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// One Wishbone channel (master-to-slave controls plus slave responses).
// The master modport drives requests; the slave modport drives responses.
interface wb_arbiter2_if;
  import wb_arbiter2_pkg::*;

  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_w;
  logic [WB_DAT_W-1:0] dat_r;
  logic [WB_SEL_W-1:0] sel;
  logic                we;
  logic                cyc;
  logic                stb;
  logic                ack;
  logic                err;

  modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
  modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);

endinterface

// File: rtl/wb_timeout_cnt.sv
// Saturating watchdog counter; o_terminal is combinational from the count register.
// i_clr has priority over i_en; TIMEOUT=0 keeps o_terminal low forever.
module wb_timeout_cnt
  import wb_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_terminal
);

  localparam int            CW    = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_terminal = (TIMEOUT > 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter, round-robin on contention, grant held for the whole cyc.
// Grant one cycle after cyc from IDLE; stalled strobes aborted with err after TIMEOUT cycles.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic       w_resp;
  logic       w_granted;
  logic       w_terminal;
  logic       w_cnt_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign w_resp    = s.ack | s.err;
  assign w_granted = (r_state == ST_GNT0) || (r_state == ST_GNT1);

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (m0.cyc && (!m1.cyc || r_last)) begin
          w_state_nxt = ST_GNT0;
          w_last_nxt  = 1'b0;
        end else if (m1.cyc) begin
          w_state_nxt = ST_GNT1;
          w_last_nxt  = 1'b1;
        end
      end
      ST_GNT0: begin
        if (!m0.cyc)                              w_state_nxt = ST_IDLE;
        else if (w_terminal && s.stb && !w_resp)  w_state_nxt = ST_ABORT;
      end
      ST_GNT1: begin
        if (!m1.cyc)                              w_state_nxt = ST_IDLE;
        else if (w_terminal && s.stb && !w_resp)  w_state_nxt = ST_ABORT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Slave side depends only on state and master inputs, never on s.ack.
  always_comb begin
    s.adr   = '0;
    s.dat_w = '0;
    s.sel   = '0;
    s.we    = 1'b0;
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    if (r_state == ST_GNT0) begin
      s.adr   = m0.adr;
      s.dat_w = m0.dat_w;
      s.sel   = m0.sel;
      s.we    = m0.we;
      s.cyc   = m0.cyc;
      s.stb   = m0.stb;
    end else if (r_state == ST_GNT1) begin
      s.adr   = m1.adr;
      s.dat_w = m1.dat_w;
      s.sel   = m1.sel;
      s.we    = m1.we;
      s.cyc   = m1.cyc;
      s.stb   = m1.stb;
    end
  end

  assign w_cnt_clr = (r_state == ST_IDLE) || w_resp || !s.stb;

  wb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_cnt_clr),
    .i_en       (w_granted),
    .o_terminal (w_terminal)
  );

  // In ABORT the last-grant bit still names the master whose strobe timed out.
  assign m0.ack   = s.ack & (r_state == ST_GNT0) & m0.stb;
  assign m1.ack   = s.ack & (r_state == ST_GNT1) & m1.stb;
  assign m0.err   = (s.err & (r_state == ST_GNT0) & m0.stb) | ((r_state == ST_ABORT) & ~r_last);
  assign m1.err   = (s.err & (r_state == ST_GNT1) & m1.stb) | ((r_state == ST_ABORT) & r_last);
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with TIMEOUT=8; inputs change 2 time units after
// the rising edge and outputs are sampled 1 unit later.
module tb_wb_arbiter2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter2_if m0_bus ();
  wb_arbiter2_if m1_bus ();
  wb_arbiter2_if s_bus ();

  wb_arbiter2 #(
    .TIMEOUT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic m0_set(input logic c, input logic st, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    m0_bus.cyc   = c;
    m0_bus.stb   = st;
    m0_bus.we    = w;
    m0_bus.adr   = a;
    m0_bus.dat_w = d;
    m0_bus.sel   = 4'hF;
  endtask

  task automatic m1_set(input logic c, input logic st, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    m1_bus.cyc   = c;
    m1_bus.stb   = st;
    m1_bus.we    = w;
    m1_bus.adr   = a;
    m1_bus.dat_w = d;
    m1_bus.sel   = 4'hF;
  endtask

  initial begin
    rst = 1'b0;
    m0_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    m1_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_bus.ack   = 1'b0;
    s_bus.err   = 1'b0;
    s_bus.dat_r = 32'h0;

    // Outputs stay quiet while reset is held, even with a request present
    #2;
    m0_set(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    settle;
    chk1("rst_s_cyc", s_bus.cyc, 1'b0);
    chk1("rst_s_stb", s_bus.stb, 1'b0);
    chk1("rst_m0_ack", m0_bus.ack, 1'b0);
    chk1("rst_m0_err", m0_bus.err, 1'b0);
    m0_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step;
    step;
    rst = 1'b1;

    // First contention: m0 wins, m1 follows after one IDLE cycle
    m0_set(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    m1_set(1'b1, 1'b1, 1'b1, 32'h200, 32'h11112222);
    settle;
    chk1("c1_idle_cyc", s_bus.cyc, 1'b0);
    step; settle;
    chk32("c1_gnt0_adr", s_bus.adr, 32'h100);
    s_bus.ack = 1'b1;
    settle;
    chk1("c1_m0_ack", m0_bus.ack, 1'b1);
    chk1("c1_m1_noack", m1_bus.ack, 1'b0);
    step;
    s_bus.ack = 1'b0;
    m0_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle;
    chk1("c1_rel_cyc", s_bus.cyc, 1'b0);
    step; settle;
    chk1("c1_gap_cyc", s_bus.cyc, 1'b0);
    step; settle;
    chk32("c1_gnt1_adr", s_bus.adr, 32'h200);
    chk1("c1_gnt1_we", s_bus.we, 1'b1);
    chk32("c1_gnt1_dat", s_bus.dat_w, 32'h11112222);
    s_bus.ack = 1'b1;
    settle;
    chk1("c1_m1_ack", m1_bus.ack, 1'b1);
    chk1("c1_m0_noack", m0_bus.ack, 1'b0);
    step;
    s_bus.ack = 1'b0;
    m1_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step;

    // Four more contentions alternate m0, m1, m0, m1
    for (int r = 0; r < 4; r++) begin
      logic w;
      w = r[0];
      m0_set(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
      m1_set(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
      settle;
      chk1("alt_idle_cyc", s_bus.cyc, 1'b0);
      step; settle;
      chk32("alt_adr", s_bus.adr, w ? 32'h200 : 32'h100);
      if (w) m0_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      else   m1_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      s_bus.ack = 1'b1;
      settle;
      chk1("alt_win_ack", w ? m1_bus.ack : m0_bus.ack, 1'b1);
      chk1("alt_lose_ack", w ? m0_bus.ack : m1_bus.ack, 1'b0);
      step;
      s_bus.ack = 1'b0;
      m0_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      m1_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step;
    end

    // Single m0 read acked in its second granted cycle
    m0_set(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    settle;
    chk1("rd_idle_cyc", s_bus.cyc, 1'b0);
    step; settle;
    chk1("rd_gnt_cyc", s_bus.cyc, 1'b1);
    chk32("rd_gnt_adr", s_bus.adr, 32'h10);
    chk1("rd_wait_ack", m0_bus.ack, 1'b0);
    step;
    s_bus.ack   = 1'b1;
    s_bus.dat_r = 32'hDEADBEEF;
    settle;
    chk1("rd_ack", m0_bus.ack, 1'b1);
    chk32("rd_dat", m0_bus.dat_r, 32'hDEADBEEF);
    step;
    s_bus.ack   = 1'b0;
    s_bus.dat_r = 32'h0;
    m0_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle;
    chk1("rd_ack_done", m0_bus.ack, 1'b0);
    step; settle;
    chk1("rd_after_cyc", s_bus.cyc, 1'b0);
    step;

    // m1 burst of four strobes is not preempted by a waiting m0
    m1_set(1'b1, 1'b1, 1'b1, 32'h300, 32'hA5A5A5A5);
    step;
    m0_set(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 4; k++) begin
      m1_bus.adr = 32'h300 + 32'(k * 4);
      s_bus.ack  = 1'b1;
      settle;
      chk32("bst_adr", s_bus.adr, 32'h300 + 32'(k * 4));
      chk1("bst_m1_ack", m1_bus.ack, 1'b1);
      chk1("bst_m0_ack", m0_bus.ack, 1'b0);
      step;
    end
    s_bus.ack = 1'b0;
    m1_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle;
    chk1("bst_rel_cyc", s_bus.cyc, 1'b0);
    chk1("bst_rel_m0_ack", m0_bus.ack, 1'b0);
    step; settle;
    chk1("bst_gap_cyc", s_bus.cyc, 1'b0);
    step; settle;
    chk1("bst_m0_cyc", s_bus.cyc, 1'b1);
    chk32("bst_m0_adr", s_bus.adr, 32'h10);
    s_bus.ack = 1'b1;
    settle;
    chk1("bst_m0_ack_now", m0_bus.ack, 1'b1);
    step;
    s_bus.ack = 1'b0;
    m0_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step;

    // Unanswered m1 write: err exactly ten cycles after the request cycle
    m1_set(1'b1, 1'b1, 1'b1, 32'h40000000, 32'hCAFEF00D);
    settle;
    chk1("wd_idle_cyc", s_bus.cyc, 1'b0);
    for (int j = 1; j <= 9; j++) begin
      step; settle;
      chk1("wd_cyc", s_bus.cyc, 1'b1);
      chk1("wd_no_err", m1_bus.err, 1'b0);
    end
    step; settle;
    chk1("wd_abort_cyc", s_bus.cyc, 1'b0);
    chk1("wd_abort_stb", s_bus.stb, 1'b0);
    chk1("wd_m1_err", m1_bus.err, 1'b1);
    chk1("wd_m0_err", m0_bus.err, 1'b0);
    chk1("wd_m1_ack", m1_bus.ack, 1'b0);
    m1_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle;
    chk1("wd_err_after_drop", m1_bus.err, 1'b1);
    step; settle;
    chk1("wd_idle_err", m1_bus.err, 1'b0);
    chk1("wd_idle_cyc2", s_bus.cyc, 1'b0);

    // Ack in the terminal-count cycle wins over the abort
    m0_set(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int j = 0; j < 9; j++) step;
    s_bus.ack = 1'b1;
    settle;
    chk1("tc_ack", m0_bus.ack, 1'b1);
    chk1("tc_no_err", m0_bus.err, 1'b0);
    step;
    s_bus.ack  = 1'b0;
    m0_bus.stb = 1'b0;
    settle;
    chk1("tc_still_gnt", s_bus.cyc, 1'b1);
    chk1("tc_no_err2", m0_bus.err, 1'b0);
    step;
    m0_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step;

    // Reset in the middle of an m0 grant
    m0_set(1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
    step; settle;
    chk1("mr_gnt_cyc", s_bus.cyc, 1'b1);
    #1;
    rst       = 1'b0;
    s_bus.ack = 1'b1;
    #1;
    chk1("mr_s_cyc", s_bus.cyc, 1'b0);
    chk1("mr_s_stb", s_bus.stb, 1'b0);
    chk1("mr_m0_ack", m0_bus.ack, 1'b0);
    chk1("mr_m0_err", m0_bus.err, 1'b0);
    m1_set(1'b1, 1'b1, 1'b0, 32'h60, 32'h0);
    step;
    rst       = 1'b1;
    s_bus.ack = 1'b0;
    settle;
    chk1("mr_idle_cyc", s_bus.cyc, 1'b0);
    step; settle;
    chk1("mr_regnt_cyc", s_bus.cyc, 1'b1);
    chk32("mr_regnt_adr", s_bus.adr, 32'h50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
